// File: rtl/ux607_perips_pkg.sv
// Shared peripheral-subsystem definitions for the register-request path.
// Field widths of the register-request queue and its entry layout.
package ux607_perips_pkg;

  localparam int unsigned REGREQ_IDX_W   = 10;
  localparam int unsigned REGREQ_EXTRA_W = 10;
  localparam int unsigned REGREQ_DATA_W  = 32;
  localparam int unsigned REGREQ_MASK_W  = 4;

  typedef struct packed {
    logic                      read;
    logic [REGREQ_IDX_W-1:0]   index;
    logic [REGREQ_DATA_W-1:0]  data;
    logic [REGREQ_MASK_W-1:0]  mask;
    logic [REGREQ_EXTRA_W-1:0] extra;
  } regreq_t;

  // Width of a requester id; never zero so single-bit storage stays legal.
  function automatic int unsigned owner_id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ux607_regreq_arb_if.sv
// Bundle of requester, queue-enqueue and response signals around the arbiter.
// master = requesters/queue/register-block side, slave = arbiter side.
interface ux607_regreq_arb_if
  import ux607_perips_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned IDX_W   = REGREQ_IDX_W,
  parameter int unsigned EXTRA_W = REGREQ_EXTRA_W,
  parameter int unsigned MAX_OUT = 2
);

  localparam int unsigned OutW = $clog2(MAX_OUT) + 1;

  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0]               req_read;
  logic [NREQ*IDX_W-1:0]         req_index;
  logic [NREQ*REGREQ_DATA_W-1:0] req_data;
  logic [NREQ*REGREQ_MASK_W-1:0] req_mask;

  logic                          out_valid;
  logic                          out_ready;
  logic                          out_read;
  logic [IDX_W-1:0]              out_index;
  logic [REGREQ_DATA_W-1:0]      out_data;
  logic [REGREQ_MASK_W-1:0]      out_mask;
  logic [EXTRA_W-1:0]            out_extra;

  logic                          in_rsp_valid;
  logic                          in_rsp_ready;
  logic [REGREQ_DATA_W-1:0]      in_rsp_data;

  logic [NREQ-1:0]               rsp_valid;
  logic [NREQ-1:0]               rsp_ready;
  logic [REGREQ_DATA_W-1:0]      rsp_data;

  logic [OutW-1:0]               outstanding;
  logic                          err_orphan;

  modport master (
    output req_valid, req_read, req_index, req_data, req_mask,
    output out_ready,
    output in_rsp_valid, in_rsp_data,
    output rsp_ready,
    input  req_ready,
    input  out_valid, out_read, out_index, out_data, out_mask, out_extra,
    input  in_rsp_ready,
    input  rsp_valid, rsp_data,
    input  outstanding, err_orphan
  );

  modport slave (
    input  req_valid, req_read, req_index, req_data, req_mask,
    input  out_ready,
    input  in_rsp_valid, in_rsp_data,
    input  rsp_ready,
    output req_ready,
    output out_valid, out_read, out_index, out_data, out_mask, out_extra,
    output in_rsp_ready,
    output rsp_valid, rsp_data,
    output outstanding, err_orphan
  );

endinterface

// File: rtl/ux607_arb_owner_fifo.sv
// In-order FIFO of requester ids for requests outstanding at the register block.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps the count.
module ux607_arb_owner_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/ux607_regreq_arb.sv
// Round-robin arbiter feeding the single register-request queue from NREQ requesters,
// with in-order routing of read responses back to the requester that issued them.
module ux607_regreq_arb
  import ux607_perips_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned IDX_W   = REGREQ_IDX_W,
  parameter int unsigned EXTRA_W = REGREQ_EXTRA_W,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  ux607_regreq_arb_if.slave      bus
);

  localparam int unsigned IdW  = owner_id_width(NREQ);
  localparam int unsigned OutW = $clog2(MAX_OUT) + 1;

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  winner;
  logic [IdW-1:0]  head_id;
  logic            any_valid;
  logic            grant_en;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [OutW-1:0] fifo_count;
  logic            err_orphan_q, err_orphan_d;

  // Search starts at ptr_q and wraps; first requester found wins.
  always_comb begin
    int unsigned k;
    k         = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr_q) + i) % NREQ;
      if (!any_valid && bus.req_valid[k]) begin
        winner    = k[IdW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // A full owner FIFO stalls grants; the pop-side never feeds back into this path.
  assign grant_en      = ~fifo_full;
  assign bus.out_valid = grant_en & any_valid;
  assign accept        = bus.out_valid & bus.out_ready;

  always_comb begin
    bus.req_ready         = '0;
    bus.req_ready[winner] = grant_en & bus.out_ready;
  end

  assign bus.out_read  = bus.req_read[winner];
  assign bus.out_index = bus.req_index[winner*IDX_W +: IDX_W];
  assign bus.out_data  = bus.req_data[winner*REGREQ_DATA_W +: REGREQ_DATA_W];
  assign bus.out_mask  = bus.req_mask[winner*REGREQ_MASK_W +: REGREQ_MASK_W];
  assign bus.out_extra = EXTRA_W'(winner);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (winner == IdW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Responses go to the FIFO head; with nothing outstanding they are swallowed.
  always_comb begin
    bus.rsp_valid = '0;
    if (!fifo_empty) begin
      bus.rsp_valid[head_id] = bus.in_rsp_valid;
    end
  end

  assign bus.in_rsp_ready = fifo_empty ? 1'b1 : bus.rsp_ready[head_id];
  assign pop              = ~fifo_empty & bus.in_rsp_valid & bus.rsp_ready[head_id];
  assign bus.rsp_data     = bus.in_rsp_data;
  assign err_orphan_d     = err_orphan_q | (fifo_empty & bus.in_rsp_valid);
  assign bus.outstanding  = fifo_count;
  assign bus.err_orphan   = err_orphan_q;

  ux607_arb_owner_fifo #(
    .Depth (MAX_OUT),
    .Width (IdW)
  ) u_owner_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (winner),
    .pop       (pop),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_ux607_regreq_arb.sv
// Directed bench for ux607_regreq_arb with NREQ=2, MAX_OUT=2.
module tb_ux607_regreq_arb;

  localparam logic [9:0]  IDX0  = 10'h155;
  localparam logic [9:0]  IDX1  = 10'h2AB;
  localparam logic [31:0] DATA0 = 32'hAAAA_0001;
  localparam logic [31:0] DATA1 = 32'hBBBB_0002;
  localparam logic [3:0]  MASK0 = 4'h3;
  localparam logic [3:0]  MASK1 = 4'hC;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  ux607_regreq_arb_if #(.NREQ(2), .IDX_W(10), .EXTRA_W(10), .MAX_OUT(2)) bus ();

  ux607_regreq_arb #(.NREQ(2), .IDX_W(10), .EXTRA_W(10), .MAX_OUT(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req_valid    = 2'b00;
    bus.req_read     = 2'b01;
    bus.req_index    = {IDX1, IDX0};
    bus.req_data     = {DATA1, DATA0};
    bus.req_mask     = {MASK1, MASK0};
    bus.out_ready    = 1'b0;
    bus.in_rsp_valid = 1'b0;
    bus.in_rsp_data  = 32'h0;
    bus.rsp_ready    = 2'b00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    #1;
    total++; if (bus.outstanding !== 2'd0) begin bad++;
      $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
    total++; if (bus.err_orphan !== 1'b0) begin bad++;
      $display("FAIL reset_err_orphan: got %b want 0", bus.err_orphan); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++;
      $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid_idle: got %b want 0", bus.out_valid); end
    total++; if (bus.in_rsp_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_rsp_ready: got %b want 1", bus.in_rsp_ready); end
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL reset_out_valid_req: got %b want 1", bus.out_valid); end
    bus.req_valid = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alternate();
    logic [9:0]  exp_grant [4] = '{10'd0, 10'd1, 10'd0, 10'd1};
    logic [1:0]  exp_rsp   [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
    logic [31:0] exp_data;
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      exp_data         = 32'hD000_0000 + 32'(c);
      bus.in_rsp_valid = (c != 0);
      bus.in_rsp_data  = exp_data;
      #1;
      total++; if (bus.out_extra !== exp_grant[c]) begin bad++;
        $display("FAIL alt_out_extra[%0d]: got %0d want %0d", c, bus.out_extra, exp_grant[c]); end
      total++; if (bus.out_index !== (exp_grant[c][0] ? IDX1 : IDX0)) begin bad++;
        $display("FAIL alt_out_index[%0d]: got %h", c, bus.out_index); end
      total++; if (bus.out_data !== (exp_grant[c][0] ? DATA1 : DATA0)) begin bad++;
        $display("FAIL alt_out_data[%0d]: got %h", c, bus.out_data); end
      total++; if (bus.req_ready !== (exp_grant[c][0] ? 2'b10 : 2'b01)) begin bad++;
        $display("FAIL alt_req_ready[%0d]: got %b", c, bus.req_ready); end
      total++; if (bus.rsp_valid !== exp_rsp[c]) begin bad++;
        $display("FAIL alt_rsp_valid[%0d]: got %b want %b", c, bus.rsp_valid, exp_rsp[c]); end
      total++; if (bus.rsp_data !== exp_data) begin bad++;
        $display("FAIL alt_rsp_data[%0d]: got %h want %h", c, bus.rsp_data, exp_data); end
      tick();
    end
    bus.req_valid = 2'b00;
    #1;
    total++; if (bus.rsp_valid !== 2'b10) begin bad++;
      $display("FAIL alt_drain_rsp_valid: got %b want 10", bus.rsp_valid); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd0) begin bad++;
      $display("FAIL alt_outstanding: got %0d want 0", bus.outstanding); end
    total++; if (bus.err_orphan !== 1'b0) begin bad++;
      $display("FAIL alt_err_orphan: got %b want 0", bus.err_orphan); end
  endtask

  task automatic test_single();
    bus.req_valid = 2'b10;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_extra !== 10'd1) begin bad++;
      $display("FAIL single_out_extra: got %0d want 1", bus.out_extra); end
    total++; if (bus.req_ready !== 2'b10) begin bad++;
      $display("FAIL single_req_ready: got %b want 10", bus.req_ready); end
    total++; if (bus.out_read !== 1'b0 || bus.out_mask !== MASK1) begin bad++;
      $display("FAIL single_fields: got read=%b mask=%h want 0/%h", bus.out_read, bus.out_mask,
               MASK1); end
    tick();
    total++; if (bus.outstanding !== 2'd1) begin bad++;
      $display("FAIL single_outstanding: got %0d want 1", bus.outstanding); end
    bus.req_valid    = 2'b11;
    bus.out_ready    = 1'b0;
    bus.in_rsp_valid = 1'b1;
    bus.rsp_ready    = 2'b11;
    #1;
    total++; if (bus.out_extra !== 10'd0) begin bad++;
      $display("FAIL single_ptr_wrap: got %0d want 0", bus.out_extra); end
    total++; if (bus.req_ready !== 2'b00) begin bad++;
      $display("FAIL single_req_ready_stall: got %b want 00", bus.req_ready); end
    total++; if (bus.rsp_valid !== 2'b10) begin bad++;
      $display("FAIL single_rsp_valid: got %b want 10", bus.rsp_valid); end
    tick();
    bus.req_valid    = 2'b00;
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd0) begin bad++;
      $display("FAIL single_drained: got %0d want 0", bus.outstanding); end
  endtask

  task automatic test_full();
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b1;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    total++; if (bus.outstanding !== 2'd2) begin bad++;
      $display("FAIL full_outstanding: got %0d want 2", bus.outstanding); end
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL full_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.req_ready !== 2'b00) begin bad++;
      $display("FAIL full_req_ready: got %b want 00", bus.req_ready); end
    bus.in_rsp_valid = 1'b1;
    bus.in_rsp_data  = 32'hCAFE_0001;
    bus.rsp_ready    = 2'b01;
    #1;
    total++; if (bus.rsp_valid !== 2'b01 || bus.in_rsp_ready !== 1'b1) begin bad++;
      $display("FAIL full_pop: got rsp_valid=%b in_rsp_ready=%b want 01/1", bus.rsp_valid,
               bus.in_rsp_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL full_no_bypass: got %b want 0", bus.out_valid); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd1) begin bad++;
      $display("FAIL full_after_pop: got %0d want 1", bus.outstanding); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_extra !== 10'd0) begin bad++;
      $display("FAIL full_resume: got valid=%b extra=%0d want 1/0", bus.out_valid,
               bus.out_extra); end
    tick();
    bus.req_valid    = 2'b00;
    bus.in_rsp_valid = 1'b1;
    bus.rsp_ready    = 2'b11;
    #1;
    total++; if (bus.rsp_valid !== 2'b10) begin bad++;
      $display("FAIL full_drain0: got %b want 10", bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 2'b01) begin bad++;
      $display("FAIL full_drain1: got %b want 01", bus.rsp_valid); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd0) begin bad++;
      $display("FAIL full_drained: got %0d want 0", bus.outstanding); end
  endtask

  task automatic test_hold();
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_extra !== 10'd0) begin bad++;
      $display("FAIL hold_grant: got %0d want 0", bus.out_extra); end
    tick();
    bus.req_valid    = 2'b00;
    bus.in_rsp_valid = 1'b1;
    bus.rsp_ready    = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.in_rsp_ready !== 1'b0) begin bad++;
        $display("FAIL hold_in_rsp_ready[%0d]: got %b want 0", c, bus.in_rsp_ready); end
      total++; if (bus.rsp_valid !== 2'b01) begin bad++;
        $display("FAIL hold_rsp_valid[%0d]: got %b want 01", c, bus.rsp_valid); end
      total++; if (bus.outstanding !== 2'd1) begin bad++;
        $display("FAIL hold_outstanding[%0d]: got %0d want 1", c, bus.outstanding); end
      tick();
    end
    bus.rsp_ready = 2'b01;
    #1;
    total++; if (bus.in_rsp_ready !== 1'b1) begin bad++;
      $display("FAIL hold_release: got %b want 1", bus.in_rsp_ready); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd0 || bus.err_orphan !== 1'b0) begin bad++;
      $display("FAIL hold_done: got out=%0d orphan=%b want 0/0", bus.outstanding,
               bus.err_orphan); end
  endtask

  task automatic test_orphan();
    bus.in_rsp_valid = 1'b1;
    bus.rsp_ready    = 2'b00;
    #1;
    total++; if (bus.in_rsp_ready !== 1'b1 || bus.rsp_valid !== 2'b00) begin bad++;
      $display("FAIL orphan_route: got ready=%b rsp_valid=%b want 1/00", bus.in_rsp_ready,
               bus.rsp_valid); end
    total++; if (bus.err_orphan !== 1'b0) begin bad++;
      $display("FAIL orphan_before_edge: got %b want 0", bus.err_orphan); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.err_orphan !== 1'b1) begin bad++;
      $display("FAIL orphan_set: got %b want 1", bus.err_orphan); end
    tick();
    tick();
    total++; if (bus.err_orphan !== 1'b1) begin bad++;
      $display("FAIL orphan_sticky: got %b want 1", bus.err_orphan); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 2'b00;
    #1;
    total++; if (bus.outstanding !== 2'd1) begin bad++;
      $display("FAIL rmid_pre: got %0d want 1", bus.outstanding); end
    reset_n = 1'b0;
    #1;
    total++; if (bus.outstanding !== 2'd0 || bus.err_orphan !== 1'b0) begin bad++;
      $display("FAIL rmid_async: got out=%0d orphan=%b want 0/0", bus.outstanding,
               bus.err_orphan); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b0;
    #1;
    total++; if (bus.out_extra !== 10'd0) begin bad++;
      $display("FAIL rmid_ptr: got %0d want 0", bus.out_extra); end
    bus.req_valid    = 2'b00;
    bus.in_rsp_valid = 1'b1;
    bus.rsp_ready    = 2'b11;
    #1;
    total++; if (bus.rsp_valid !== 2'b00 || bus.in_rsp_ready !== 1'b1) begin bad++;
      $display("FAIL rmid_late_rsp: got rsp_valid=%b ready=%b want 00/1", bus.rsp_valid,
               bus.in_rsp_ready); end
    tick();
    bus.in_rsp_valid = 1'b0;
    #1;
    total++; if (bus.err_orphan !== 1'b1) begin bad++;
      $display("FAIL rmid_orphan: got %b want 1", bus.err_orphan); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alternate();
    test_single();
    test_full();
    test_hold();
    test_orphan();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ux607_regreq_arb.md
# ux607_regreq_arb

Round-robin arbiter and response router that shares the single-entry peripheral register-request queue (read/index/data/mask/extra channel) between `NREQ` requesters, e.g. core LSU, debug module and DMA config port. It grants one request per cycle into the queue's enqueue side, records the owner of each outstanding request in an in-order owner FIFO, and steers the returned read data back to that owner. It sits between the requesters and the register-request queue in the peripheral subsystem.

## Interface
- `NREQ`, 2: number of requesters (2..8)
- `IDX_W`, 10: register index width
- `EXTRA_W`, 10: extra/tag field width; must be ≥ clog2(NREQ)
- `MAX_OUT`, 2: outstanding requests tracked (owner FIFO depth, power of 2)

- `clock`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept
- `req_read`  in  NREQ  1 = read, 0 = write
- `req_index`  in  NREQ*IDX_W  packed register index, requester k at [k*IDX_W +: IDX_W]
- `req_data`  in  NREQ*32  packed write data
- `req_mask`  in  NREQ*4  packed byte mask
- `out_valid` / `out_ready`  out / in  1  enqueue handshake to the register-request queue
- `out_read`, `out_index`, `out_data`, `out_mask`  out  1/IDX_W/32/4  granted request fields
- `out_extra`  out  EXTRA_W  granted requester id, zero-extended
- `in_rsp_valid` / `in_rsp_ready`  in / out  1  response from register block
- `in_rsp_data`  in  32  response read data (don't-care for writes)
- `rsp_valid`  out  NREQ  per-requester response valid
- `rsp_ready`  in  NREQ  per-requester response accept
- `rsp_data`  out  32  shared response data, equals `in_rsp_data`
- `outstanding`  out  clog2(MAX_OUT)+1  owner FIFO occupancy
- `err_orphan`  out  1  sticky: response arrived with no outstanding request

## Operation
- Round-robin pointer `ptr` (clog2(NREQ) bits). Winner is the first k with `req_valid[k]` in order ptr, ptr+1, … mod NREQ.
- Grant is enabled when owner FIFO not full. `out_valid` = enabled and any `req_valid`; out fields mux from the winner.
- `req_ready[winner]` = enabled and `out_ready`; all other `req_ready` bits 0.
- Accepted grant (`out_valid & out_ready`): push winner id into owner FIFO; `ptr` ← winner+1 mod NREQ. No accept: `ptr` holds.
- Responses return in order. With FIFO non-empty, head id h: `rsp_valid[h]` = `in_rsp_valid`, others 0; `in_rsp_ready` = `rsp_ready[h]`; handshake pops head.
- FIFO empty: `in_rsp_ready` = 1, `rsp_valid` = 0, response discarded, `err_orphan` set to 1 until reset.
- Full FIFO blocks grant even when a pop occurs in the same cycle (no response-to-request combinational path). Push and pop in the same cycle when not full: occupancy unchanged.
- Reset (asynchronous, any time): `ptr`=0, FIFO empty, `outstanding`=0, `err_orphan`=0; in-flight requests are forgotten and later responses raise `err_orphan`.

## Timing
- Request path fully combinational: request presented in cycle t is accepted into the queue in cycle t when granted.
- Response path combinational: `in_rsp_valid` → `rsp_valid[h]` in the same cycle.
- `ptr`, FIFO pointers, `outstanding` and `err_orphan` update on the rising `clock` edge after the handshake.
- Reset values: `out_valid`=0 unless requests are present (FIFO empty after reset), `rsp_valid`=0, `outstanding`=0, `err_orphan`=0.
- `req_*` must stay stable while `req_valid` is high and not accepted.

## Structure
- Shared package `ux607_perips_pkg`: `REGREQ_IDX_W`=10, `REGREQ_EXTRA_W`=10, `REGREQ_DATA_W`=32, `REGREQ_MASK_W`=4, and a regreq struct typedef {read, index, data, mask, extra}.
- One sub-module: `ux607_arb_owner_fifo`. This is a `MAX_OUT`-deep, clog2(NREQ)-wide synchronous FIFO with push, pop, full, empty and count outputs. Arbitration and routing stay in the top.

## Test plan
- NREQ=2, both valid continuously, `out_ready`=1, responses returned every cycle: grants alternate 0,1,0,1; `out_extra` alternates 0,1; each `rsp_valid[k]` follows its own grant order.
- Only requester 1 valid with `ptr`=0: grant 1 immediately, `ptr`→0 after accept.
- Two accepted requests and no responses (MAX_OUT=2): `outstanding`=2, `out_valid`=0, all `req_ready`=0. Return one response with `rsp_ready[h]`=1: `outstanding`=1 next cycle, grant resumes the following cycle.
- `in_rsp_valid` with empty FIFO: `in_rsp_ready`=1, `rsp_valid`=0, `err_orphan`=1 next edge and held.
- Head owner holds `rsp_ready`=0 for 3 cycles: `in_rsp_ready`=0, and FIFO and `rsp_valid[h]`=1 held for those cycles.
- Assert `reset_n`=0 mid-transfer with `outstanding`=1: all state returns to reset values immediately. A subsequent response sets `err_orphan`.
